// File: rtl/silly_eval_scheduler.sv
// Round-robin evaluation scheduler with a truth-table self-test sweep.
// Requesters share one evaluator, f(a,b,c) = 1 for {a,b,c} in {000, 100, 101}.
// A sweep evaluates all eight inputs once and compares the captured table
// against the expected 8'h31.
module silly_eval_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned IdW  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [3*N_REQ-1:0] abc_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic               rsp_valid_o,
  output logic [IdW-1:0]     rsp_id_o,
  output logic               rsp_y_o,
  input  logic               bist_start_i,
  output logic               bist_busy_o,
  output logic               bist_done_o,
  output logic [7:0]         bist_table_o,
  output logic               bist_pass_o,
  output logic [CNT_W-1:0]   eval_count_o
);

  localparam logic [7:0] ExpTable = 8'h31;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_y_q, rsp_y_d;
  logic [2:0]       k_q, k_d;
  logic [7:0]       table_q, table_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_valid;
  int unsigned      gnt_idx;
  logic [2:0]       gnt_abc;

  function automatic logic eval_f(input logic [2:0] k);
    return (k == 3'b000) || (k == 3'b100) || (k == 3'b101);
  endfunction

  // Round-robin pick: first requester at or after ptr, wrapping.
  // Grants only in IdLE and never while reset is held.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = 0;
    idx       = 0;
    ack_o     = '0;
    if (state_q == StIdle && reset_ni) begin
      for (int unsigned o = 0; o < N_REQ; o++) begin
        idx = (int'(ptr_q) + o) % N_REQ;
        if (!gnt_valid && req_i[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx;
        end
      end
      if (gnt_valid) ack_o[gnt_idx] = 1'b1;
    end
    gnt_abc = abc_i[3*gnt_idx +: 3];
  end

  // Next-state for FSM, arbiter pointer, response, sweep and counter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = gnt_valid;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    k_d         = k_q;
    table_d     = table_q;
    pass_d      = pass_q;
    cnt_d       = cnt_q;

    if (gnt_valid) begin
      rsp_id_d = IdW'(gnt_idx);
      rsp_y_d  = eval_f(gnt_abc);
      ptr_d    = (gnt_idx == N_REQ - 1) ? '0 : IdW'(gnt_idx + 1);
    end

    unique case (state_q)
      StIdle: begin
        if (bist_start_i) begin
          state_d = StSweep;
          k_d     = '0;
          table_d = '0;
        end
      end
      StSweep: begin
        table_d[k_q] = eval_f(k_q);
        k_d          = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = StDone;
          // Pass flag lands together with the done pulse.
          pass_d  = (table_d == ExpTable);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if ((gnt_valid || state_q == StSweep) && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 1'b0;
      k_q         <= '0;
      table_q     <= '0;
      pass_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      k_q         <= k_d;
      table_q     <= table_d;
      pass_q      <= pass_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_y_o      = rsp_y_q;
  assign bist_busy_o  = (state_q == StSweep);
  assign bist_done_o  = (state_q == StDone);
  assign bist_table_o = table_q;
  assign bist_pass_o  = pass_q;
  assign eval_count_o = cnt_q;

endmodule
